sram_port_arbiter: RTL
======================

# sram_port_arbiter

Sequencer/arbiter owning one port of a dual-port synchronous RAM (registered read, one-cycle read latency, `cen` qualified write). It shares that port between a CPU bus requester and a DMA requester (sprite/palette list copy) with round-robin arbitration. A built-in clear engine fills the whole RAM with a constant after reset or on command. The other RAM port stays with video fetch and is untouched by this block.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 10, RAM address width; the clear spans 2**ADDR_WIDTH words.
- `CLEAR_ON_RESET`, 1, 1 = run the clear engine automatically after reset.
- `CLEAR_VALUE`, 0, word written by the clear engine.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request; held high until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr` in ADDR_WIDTH; `cpu_wdata` in DATA_WIDTH.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out DATA_WIDTH: read data, valid when `cpu_ack` is high.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`: same as the CPU set.
- `clr_start` in 1: one-cycle pulse requesting a full clear.
- `clr_busy` out 1: high while a clear is pending or running.
- `ram_cen`, `ram_we` out 1; `ram_addr` out ADDR_WIDTH; `ram_din` out DATA_WIDTH: registered drive to the RAM port.
- `ram_q` in DATA_WIDTH: RAM port output; valid on the cycle after the access cycle.

## Operation
- States: CLEAR, IDLE, ISSUE, READ, ACK.
- Reset values:
  - Outputs `ram_*`, both `*_ack` and both `*_rdata` are 0.
  - `clr_busy` = CLEAR_ON_RESET.
  - State = CLEAR if CLEAR_ON_RESET, otherwise IDLE.
  - Clear counter = 0.
  - `last_grant` = DMA, so the CPU wins the first tie.
  - `clr_pending` = 0.
- CLEAR:
  - Each cycle drives `ram_cen`=`ram_we`=1, `ram_addr`=counter, `ram_din`=CLEAR_VALUE, then increments the counter.
  - After the write to address 2**ADDR_WIDTH-1: go to IDLE, clear the counter (wrap to 0), drop `clr_busy`.
  - Requests are not serviced during CLEAR.
- IDLE:
  - If `clr_pending` or `clr_start` is set, go to CLEAR and set `clr_busy`. Clear has priority over requests.
  - Otherwise, if exactly one request is high, grant it. If both are high, grant the requester not equal to `last_grant`.
  - On grant: latch the winner's we/addr/wdata into `ram_*`, set `ram_cen`=1, update `last_grant`, go to ISSUE.
- ISSUE: the RAM access cycle. Go to READ and drop `ram_cen`/`ram_we`.
- READ:
  - `ram_q` is valid in this cycle. Latch it into the winner's `*_rdata`; the other requester's rdata holds its value.
  - Set the winner's `*_ack`, go to ACK.
  - Writes also latch `ram_q`; that data is don't-care.
- ACK: the winner's ack is high for exactly this cycle. Clear it and go to IDLE.
- `clr_start` outside IDLE and CLEAR: set `clr_pending` and `clr_busy`. The clear starts at the next IDLE.
- `clr_start` during CLEAR: ignored; the clear is not restarted.
- Address and data are passed through unchanged. There is no width conversion and no bounds check.

## Timing
- Request high in IDLE cycle N:
  - ISSUE in N+1 (`ram_cen`=1 with the latched addr/we/din).
  - READ in N+2.
  - `*_ack` and `*_rdata` valid in N+3.
  - Back to IDLE in N+4.
- One access per 4 cycles; no pipelining.
- The requester must deassert `req` on the edge ending its ack cycle. A request still high in N+4 is treated as a new request.
- Competing request, worst-case wait: one other access (4 cycles), or a clear in progress.
- Clear after reset (CLEAR_ON_RESET=1):
  - Writes occupy cycles 1..2**ADDR_WIDTH, where cycle 0 is the first cycle with `reset` low.
  - `clr_busy` falls at the start of cycle 2**ADDR_WIDTH+1.
  - The first grant is possible in that same cycle.
- `reset` asserted mid-access or mid-clear: the next edge forces the reset values. No ack is issued for the interrupted access. With CLEAR_ON_RESET=1 the clear restarts at address 0.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=8'hA5 -> 16 write cycles to addresses 0..15 with din A5; `clr_busy` low on the 17th cycle; a CPU read of addr 7 returns A5 with ack 3 cycles after grant.
- CPU writes 8'h3C to addr 5, then DMA reads addr 5 -> DMA ack with `dma_rdata`=3C; `cpu_rdata` unchanged.
- `cpu_req` and `dma_req` rise together after reset -> CPU granted first, DMA granted in the IDLE cycle after the CPU ack; on the next simultaneous pair the grant order follows round-robin.
- `clr_start` pulsed during the DMA ISSUE cycle -> DMA access completes with ack; CLEAR begins in the next IDLE; a CPU request raised meanwhile is serviced only after `clr_busy` falls.
- `reset` asserted during READ -> no ack; all outputs return to their reset values on the next edge; the clear restarts from address 0.
- `clr_start` pulsed during CLEAR -> clear length unchanged (exactly 2**ADDR_WIDTH writes); no second clear follows.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Single-port RAM sequencer: round-robin CPU/DMA sharing plus a full-RAM clear engine.
// One access per four cycles; all RAM drive signals are registered.
module sram_port_arbiter #(
    parameter int                  DATA_WIDTH     = 8,
    parameter int                  ADDR_WIDTH     = 10,
    parameter bit                  CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  ram_cen,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ISSUE,
        S_READ,
        S_ACK
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t                state, state_n;
    // Extra MSB marks the trailing cycle in which the last clear write lands.
    logic [ADDR_WIDTH:0]   cnt, cnt_n;
    logic                  last_dma, last_dma_n;
    logic                  pending, pending_n;
    logic                  busy_n;
    logic                  cen_n, we_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] din_n;
    logic                  cpu_ack_n, dma_ack_n;
    logic [DATA_WIDTH-1:0] cpu_rdata_n, dma_rdata_n;
    logic                  pick_dma;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST_STATE;
            cnt       <= '0;
            last_dma  <= 1'b1;
            pending   <= 1'b0;
            clr_busy  <= CLEAR_ON_RESET;
            ram_cen   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last_dma  <= last_dma_n;
            pending   <= pending_n;
            clr_busy  <= busy_n;
            ram_cen   <= cen_n;
            ram_we    <= we_n;
            ram_addr  <= addr_n;
            ram_din   <= din_n;
            cpu_ack   <= cpu_ack_n;
            dma_ack   <= dma_ack_n;
            cpu_rdata <= cpu_rdata_n;
            dma_rdata <= dma_rdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_dma_n  = last_dma;
        pending_n   = pending;
        busy_n      = clr_busy;
        cen_n       = ram_cen;
        we_n        = ram_we;
        addr_n      = ram_addr;
        din_n       = ram_din;
        cpu_ack_n   = cpu_ack;
        dma_ack_n   = dma_ack;
        cpu_rdata_n = cpu_rdata;
        dma_rdata_n = dma_rdata;
        pick_dma    = dma_req && (!cpu_req || !last_dma);

        unique case (state)
            S_CLEAR: begin
                if (cnt[ADDR_WIDTH]) begin
                    cen_n   = 1'b0;
                    we_n    = 1'b0;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    cen_n  = 1'b1;
                    we_n   = 1'b1;
                    addr_n = cnt[ADDR_WIDTH-1:0];
                    din_n  = CLEAR_VALUE;
                    cnt_n  = cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (pending || clr_start) begin
                    pending_n = 1'b0;
                    busy_n    = 1'b1;
                    state_n   = S_CLEAR;
                end else if (cpu_req || dma_req) begin
                    last_dma_n = pick_dma;
                    cen_n      = 1'b1;
                    we_n       = pick_dma ? dma_we    : cpu_we;
                    addr_n     = pick_dma ? dma_addr  : cpu_addr;
                    din_n      = pick_dma ? dma_wdata : cpu_wdata;
                    state_n    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cen_n   = 1'b0;
                we_n    = 1'b0;
                state_n = S_READ;
            end
            S_READ: begin
                if (last_dma) begin
                    dma_rdata_n = ram_q;
                    dma_ack_n   = 1'b1;
                end else begin
                    cpu_rdata_n = ram_q;
                    cpu_ack_n   = 1'b1;
                end
                state_n = S_ACK;
            end
            S_ACK: begin
                cpu_ack_n = 1'b0;
                dma_ack_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // A clear requested mid-access waits for the next IDLE.
        if (clr_start && (state == S_ISSUE || state == S_READ ||
                          state == S_ACK)) begin
            pending_n = 1'b1;
            busy_n    = 1'b1;
        end
    end

endmodule
